// File: rtl/cu_pkg.sv
// cu_pkg: shared definitions for the accumulator-CPU control unit.
//   - bus widths (opcode, control bus, ALU function select)
//   - opcode values and the opcode-class encoding used by the sequencer
//   - FSM state encoding
//   - bit positions of control strobes C0..C15 inside ctrl
//   - one-hot ALU function codes plus opcode -> class / function helpers
// Optional build macro: CU_SINGLE_STEP_EN adds the STEP state.
package cu_pkg;

  localparam int OPW   = 8;
  localparam int CTRLW = 16;
  localparam int FNW   = 11;

  // Opcodes
  localparam logic [OPW-1:0] OP_HALT  = 8'h00;
  localparam logic [OPW-1:0] OP_LOAD  = 8'h01;
  localparam logic [OPW-1:0] OP_STORE = 8'h02;
  localparam logic [OPW-1:0] OP_ADD   = 8'h03;
  localparam logic [OPW-1:0] OP_SUB   = 8'h04;
  localparam logic [OPW-1:0] OP_MPY   = 8'h05;
  localparam logic [OPW-1:0] OP_DIV   = 8'h06;
  localparam logic [OPW-1:0] OP_AND   = 8'h07;
  localparam logic [OPW-1:0] OP_OR    = 8'h08;
  localparam logic [OPW-1:0] OP_NOT   = 8'h09;
  localparam logic [OPW-1:0] OP_SHL   = 8'h0A;
  localparam logic [OPW-1:0] OP_SHR   = 8'h0B;
  localparam logic [OPW-1:0] OP_JMP   = 8'h0C;
  localparam logic [OPW-1:0] OP_JGEZ  = 8'h0D;

  // FSM states
  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_F0   = 4'd1,
    S_F1   = 4'd2,
    S_F2   = 4'd3,
    S_DEC  = 4'd4,
    S_OPA  = 4'd5,
    S_MRD  = 4'd6,
    S_LDX  = 4'd7,
    S_BRX  = 4'd8,
    S_ALU  = 4'd9,
    S_STW  = 4'd10,
    S_MWR  = 4'd11,
    S_JMP  = 4'd12,
    S_JGEZ = 4'd13,
    S_HALT = 4'd14
`ifdef CU_SINGLE_STEP_EN
    ,
    S_STEP = 4'd15
`endif
  } state_t;

  // Control strobe bit positions (ctrl[i] = Ci)
  localparam int C_RAM_EN     = 0;   // RAM access enable
  localparam int C_PC_TO_MAR  = 2;
  localparam int C_PC_LOAD    = 3;   // MBR address -> PC (jump)
  localparam int C_IR_LOAD    = 4;   // MBR -> IR
  localparam int C_MBR_LOAD   = 5;   // memory -> MBR
  localparam int C_BR_LOAD    = 6;   // MBR -> BR
  localparam int C_OPA_TO_MAR = 8;   // MBR[7:0] -> MAR
  localparam int C_ALU_TO_ACC = 9;
  localparam int C_MBR_TO_ACC = 10;
  localparam int C_ACC_TO_MBR = 11;
  localparam int C_RAM_WR     = 12;
  localparam int C_PC_INC     = 15;

  // One-hot ALU function codes (fn k -> bit k)
  localparam logic [FNW-1:0] FN_ADD = 11'h002;
  localparam logic [FNW-1:0] FN_SUB = 11'h004;
  localparam logic [FNW-1:0] FN_MPY = 11'h008;
  localparam logic [FNW-1:0] FN_DIV = 11'h010;
  localparam logic [FNW-1:0] FN_AND = 11'h020;
  localparam logic [FNW-1:0] FN_OR  = 11'h040;
  localparam logic [FNW-1:0] FN_SHL = 11'h100;
  localparam logic [FNW-1:0] FN_SHR = 11'h200;
  localparam logic [FNW-1:0] FN_NOT = 11'h400;

  // Opcode classes: each class shares one state path after DEC
  typedef enum logic [2:0] {
    CL_LD   = 3'd0,
    CL_ST   = 3'd1,
    CL_BIN  = 3'd2,
    CL_UN   = 3'd3,
    CL_JMP  = 3'd4,
    CL_JGEZ = 3'd5,
    CL_HALT = 3'd6,
    CL_ILL  = 3'd7
  } cls_t;

  function automatic cls_t op_class(input logic [OPW-1:0] op);
    case (op)
      OP_HALT:                                         return CL_HALT;
      OP_LOAD:                                         return CL_LD;
      OP_STORE:                                        return CL_ST;
      OP_ADD, OP_SUB, OP_MPY, OP_DIV, OP_AND, OP_OR:   return CL_BIN;
      OP_NOT, OP_SHL, OP_SHR:                          return CL_UN;
      OP_JMP:                                          return CL_JMP;
      OP_JGEZ:                                         return CL_JGEZ;
      default:                                         return CL_ILL;
    endcase
  endfunction

  function automatic logic [FNW-1:0] op_fn(input logic [OPW-1:0] op);
    case (op)
      OP_ADD:  return FN_ADD;
      OP_SUB:  return FN_SUB;
      OP_MPY:  return FN_MPY;
      OP_DIV:  return FN_DIV;
      OP_AND:  return FN_AND;
      OP_OR:   return FN_OR;
      OP_NOT:  return FN_NOT;
      OP_SHL:  return FN_SHL;
      OP_SHR:  return FN_SHR;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/cu_ctrl_decode.sv
// cu_ctrl_decode: combinational strobe decoder for the control unit.
// Ports:
//   state    in  current FSM state (registered in the top)
//   cls      in  latched opcode class
//   fn       in  latched one-hot ALU function
//   acc_sign in  ACC[15]; only gates C3 in JGEZ
//   ctrl     out control strobes C0..C15
//   alu_fn   out one-hot ALU function, nonzero only in ALU state
module cu_ctrl_decode
  import cu_pkg::*;
(
  input  state_t           state,
  input  cls_t             cls,
  input  logic [FNW-1:0]   fn,
  input  logic             acc_sign,
  output logic [CTRLW-1:0] ctrl,
  output logic [FNW-1:0]   alu_fn
);

  logic alu_en;

  always_comb begin
    ctrl = '0;
    case (state)
      S_F0: ctrl[C_PC_TO_MAR] = 1'b1;
      S_F1: begin
        ctrl[C_RAM_EN]   = 1'b1;
        ctrl[C_MBR_LOAD] = 1'b1;
        ctrl[C_PC_INC]   = 1'b1;
      end
      S_F2:  ctrl[C_IR_LOAD]    = 1'b1;
      S_OPA: ctrl[C_OPA_TO_MAR] = 1'b1;
      S_MRD: begin
        ctrl[C_RAM_EN]   = 1'b1;
        ctrl[C_MBR_LOAD] = 1'b1;
      end
      S_LDX: ctrl[C_MBR_TO_ACC] = 1'b1;
      S_BRX: ctrl[C_BR_LOAD]    = 1'b1;
      S_ALU: ctrl[C_ALU_TO_ACC] = 1'b1;
      S_STW: ctrl[C_ACC_TO_MBR] = 1'b1;
      S_MWR: begin
        ctrl[C_RAM_EN] = 1'b1;
        ctrl[C_RAM_WR] = 1'b1;
      end
      S_JMP:  ctrl[C_PC_LOAD] = 1'b1;
      // The only strobe with a combinational input dependency.
      S_JGEZ: ctrl[C_PC_LOAD] = ~acc_sign;
      default: ctrl = '0;
    endcase
  end

  // Gate on class too, so a stale function latch can never leak out.
  assign alu_en = (state == S_ALU) && ((cls == CL_BIN) || (cls == CL_UN));

  generate
    for (genvar gi = 0; gi < FNW; gi++) begin : g_fn
      assign alu_fn[gi] = alu_en & fn[gi];
    end
  endgenerate

endmodule

// File: rtl/cu_sequencer.sv
// cu_sequencer: hardwired fetch/decode/execute Moore FSM for the 16-bit
// accumulator CPU.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   run         1 = execute, 0 = stop at the next instruction boundary
//   step        (CU_SINGLE_STEP_EN only) advance one instruction on rising edge
//   opcode      IR output, sampled only in DEC
//   acc_sign    ACC[15], used for JGEZ
//   ctrl        strobes C0..C15
//   alu_fn      one-hot ALU function select
//   instr_done  high in the last state of each instruction
//   halted      sticky, set by HALT or an illegal opcode
//   illegal     sticky, set by an undefined opcode
// Build macro: CU_SINGLE_STEP_EN enables the step input and STEP state.
module cu_sequencer
  import cu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
`ifdef CU_SINGLE_STEP_EN
  input  logic             step,
`endif
  input  logic [OPW-1:0]   opcode,
  input  logic             acc_sign,
  output logic [CTRLW-1:0] ctrl,
  output logic [FNW-1:0]   alu_fn,
  output logic             instr_done,
  output logic             halted,
  output logic             illegal
);

  state_t         state_reg, state_next;
  cls_t           cls_reg, cls_next, dec_cls;
  logic [FNW-1:0] fn_reg, fn_next;
  logic           halted_reg, halted_next;
  logic           illegal_reg, illegal_next;
  state_t         done_target;

`ifdef CU_SINGLE_STEP_EN
  logic step_prev_reg;
  logic step_rise;

  // Edge detect so a held step advances exactly one instruction.
  assign step_rise = step & ~step_prev_reg;
`endif

  assign dec_cls = op_class(opcode);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      cls_reg     <= CL_HALT;
      fn_reg      <= '0;
      halted_reg  <= 1'b0;
      illegal_reg <= 1'b0;
`ifdef CU_SINGLE_STEP_EN
      step_prev_reg <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      cls_reg     <= cls_next;
      fn_reg      <= fn_next;
      halted_reg  <= halted_next;
      illegal_reg <= illegal_next;
`ifdef CU_SINGLE_STEP_EN
      step_prev_reg <= step;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    cls_next     = cls_reg;
    fn_next      = fn_reg;
    halted_next  = halted_reg;
    illegal_next = illegal_reg;

`ifdef CU_SINGLE_STEP_EN
    done_target = S_STEP;
`else
    done_target = run ? S_F0 : S_IDLE;
`endif

    case (state_reg)
      S_IDLE: if (run) state_next = S_F0;
      S_F0:   state_next = S_F1;
      S_F1:   state_next = S_F2;
      S_F2:   state_next = S_DEC;
      S_DEC: begin
        // Latch class and function here; later opcode changes are ignored.
        cls_next = dec_cls;
        fn_next  = op_fn(opcode);
        case (dec_cls)
          CL_LD, CL_ST, CL_BIN: state_next = S_OPA;
          CL_UN:                state_next = S_ALU;
          CL_JMP:               state_next = S_JMP;
          CL_JGEZ:              state_next = S_JGEZ;
          CL_HALT: begin
            state_next  = S_HALT;
            halted_next = 1'b1;
          end
          default: begin
            state_next   = S_HALT;
            halted_next  = 1'b1;
            illegal_next = 1'b1;
          end
        endcase
      end
      S_OPA: state_next = (cls_reg == CL_ST) ? S_STW : S_MRD;
      S_MRD: state_next = (cls_reg == CL_LD) ? S_LDX : S_BRX;
      S_BRX: state_next = S_ALU;
      S_STW: state_next = S_MWR;
      S_LDX, S_MWR, S_ALU, S_JMP, S_JGEZ: state_next = done_target;
      S_HALT: state_next = S_HALT;
`ifdef CU_SINGLE_STEP_EN
      S_STEP: if (step_rise) state_next = run ? S_F0 : S_IDLE;
`endif
      default: state_next = S_IDLE;
    endcase
  end

  cu_ctrl_decode u_decode (
    .state    (state_reg),
    .cls      (cls_reg),
    .fn       (fn_reg),
    .acc_sign (acc_sign),
    .ctrl     (ctrl),
    .alu_fn   (alu_fn)
  );

  assign instr_done = (state_reg == S_LDX) || (state_reg == S_MWR) ||
                      (state_reg == S_ALU) || (state_reg == S_JMP) ||
                      (state_reg == S_JGEZ);
  assign halted  = halted_reg;
  assign illegal = illegal_reg;

endmodule

// File: doc/cu_sequencer.md
Name: cu_sequencer

Overview:
Hardwired control unit for the 16-bit accumulator CPU. Runs fetch/decode/execute as a Moore FSM. Drives control strobes C0..C15 to MAR/MBR/PC/IR/BR/ACC/RAM and the one-hot ALU function select. Reads only the IR opcode and the ACC sign bit.

Parameters:
OPW, 8, opcode width (IR output width)
CTRLW, 16, control bus width; bit i = strobe Ci
FNW, 11, one-hot ALU function width

Ports:
clk  in  1  system clock
rst  in  1  reset
run  in  1  level; 1 = execute instructions, 0 = stop at next instruction boundary
opcode  in  OPW  IR output
acc_sign  in  1  ACC[15]
ctrl  out  CTRLW  strobes C0..C15 (C13 reserved, always 0)
alu_fn  out  FNW  one-hot ALU function select
instr_done  out  1  one-cycle pulse in last state of each instruction
halted  out  1  sticky; set by HALT or illegal opcode
illegal  out  1  sticky; set by undefined opcode

Behaviour:
- One clock; reset is synchronous and active-high (clk, rst). Reset forces state IDLE. All outputs 0. Reset wins over every other event, including mid-instruction (e.g. during MEMWR, the next cycle is IDLE with ctrl=0).
- ctrl and alu_fn are decoded from the registered state (plus latched opcode class) only. No combinational path from run or acc_sign to ctrl, except C3 in JGEZ.
- alu_fn is nonzero only in ALU state, otherwise 0. At most one alu_fn bit is set.
- States and strobes:
  - IDLE: ctrl 0. Goes to F0 when run=1.
  - F0: C2 (PC->MAR).
  - F1: C0|C5|C15 (mem->MBR, PC++).
  - F2: C4 (MBR->IR).
  - DEC: no strobes. Samples opcode and branches.
  - OPA: C8 (MBR[7:0]->MAR).
  - MRD: C0|C5.
  - LDX: C10 (MBR->ACC).
  - BRX: C6 (MBR->BR).
  - ALU: C9 plus alu_fn.
  - STW: C11 (ACC->MBR).
  - MWR: C0|C12 (write).
  - JMP: C3.
  - JGEZ: C3 only if acc_sign=0.
  - HALT: ctrl 0, halted=1. Leaves only on rst.
- Opcodes:
  - 0x00 HALT.
  - 0x01 LOAD: OPA,MRD,LDX.
  - 0x02 STORE: OPA,STW,MWR.
  - 0x03 ADD (fn1), 0x04 SUB (fn2), 0x05 MPY (fn3), 0x06 DIV (fn4), 0x07 AND (fn5), 0x08 OR (fn6): OPA,MRD,BRX,ALU.
  - 0x09 NOT (fn10), 0x0A SHL (fn8), 0x0B SHR (fn9): ALU.
  - 0x0C JMP: JMP.
  - 0x0D JGEZ: JGEZ.
  - Any other value: illegal=1, then HALT.
- Latency F0..DEC is 4 cycles, so totals are: LOAD/STORE 7, binary ALU 8, unary/jumps 5.
- instr_done is asserted in the final state of each instruction (LDX, MWR, ALU, JMP, JGEZ). From that state the FSM goes to F0 if run=1, else IDLE.
- run dropping mid-instruction does not abort; the instruction completes.
- The opcode class is latched in DEC, so opcode changes after DEC are ignored.

Optional Feature:
CU_SINGLE_STEP_EN.
- Defined: adds input step (1 bit) and state STEP. After instr_done the FSM enters STEP (ctrl 0) and waits for step=1 to go to F0 (IDLE if run=0). A step held high advances only one instruction: requires rising-edge detect, registered.
- Undefined: no step port, no STEP state. Behaviour as above.

Decomposition:
- Package cu_pkg holds:
  - opcode localparams
  - state encoding
  - Ci bit-index constants
  - FN_* one-hot constants
  - opcode-class encoding (LD/ST/BIN/UN/JMP/JGEZ/HALT/ILL)
- Sub-module cu_ctrl_decode: combinational (state, class, fn latch, acc_sign) -> ctrl/alu_fn.
- Top holds the state register, opcode latch and sticky flags.

Test Plan:
1. rst 1 cycle, run=1, opcode=0x01 -> ctrl sequence 0x0004, 0x8021, 0x0010, 0x0000, 0x0100, 0x0021, 0x0400. instr_done in cycle 7 only. alu_fn 0 throughout.
2. opcode=0x03 -> after DEC: 0x0100, 0x0021, 0x0040, then 0x0200 with alu_fn=0x002, instr_done=1. Next cycle is F0 (0x0004).
3. opcode=0x02 -> after DEC: 0x0100, 0x0800, 0x1001. C12 asserted exactly one cycle.
4. opcode=0x0D:
   - acc_sign=1 -> ctrl 0x0000 in JGEZ state, instr_done=1.
   - Repeat with acc_sign=0 -> ctrl 0x0008.
5. Error and stop paths:
   - opcode=0xFF -> one cycle after DEC: illegal=1, halted=1, ctrl 0 indefinitely with run=1. rst clears both.
   - rst asserted during MRD -> next cycle IDLE, all outputs 0.
   - run=0 during OPA -> instruction completes, then IDLE.
6. CU_SINGLE_STEP_EN defined, step held 1 for 20 cycles -> exactly one further instruction executes, then STEP state holds ctrl 0.
